// File: rtl/dff_bank_arbiter_if.sv
// dff_bank_arbiter_if: requester-side bus of the shared-register arbiter.
interface dff_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ack;
  logic [WIDTH-1:0] q;
  logic busy;
  logic [IDW-1:0] last_id;
  modport master (output req, wdata, input grant, ack, q, busy, last_id);
  modport slave (input req, wdata, output grant, ack, q, busy, last_id);
endinterface

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin sharing of one WIDTH-bit register among NREQ requesters.
module dff_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW = 2
) (
  input logic clk,
  input logic rst,
  dff_bank_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
  state_t state;
  logic [IDW-1:0] ptr, win, sel, idx;
  logic [NREQ-1:0] sel_oh;
  // Scan downwards from ptr+NREQ-1 so the last hit is the first requester at or after ptr.
  always_comb begin
    sel = ptr;
    idx = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      sel = bus.req[idx] ? idx : sel;
    end
    sel_oh = NREQ'(1) << sel;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bus.grant <= '0;
      bus.ack <= '0;
      bus.q <= '0;
      bus.busy <= 1'b0;
      bus.last_id <= '0;
      ptr <= '0;
      win <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          state <= GRANT;
          win <= sel;
          bus.grant <= sel_oh;
          bus.busy <= 1'b1;
        end
        GRANT: if (bus.req[win]) begin
          state <= ACK;
          bus.q <= bus.wdata[win*WIDTH +: WIDTH];
          bus.ack <= bus.grant;
          bus.last_id <= win;
        end else begin
          state <= IDLE;
          bus.grant <= '0;
          bus.busy <= 1'b0;
        end
        ACK: begin
          state <= IDLE;
          bus.grant <= '0;
          bus.ack <= '0;
          bus.busy <= 1'b0;
          ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
